// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Beat-kind and state encodings for the immediate narrower.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    localparam logic [1:0] SIMM  = 2'b00;
    localparam logic [1:0] UPPER = 2'b01;
    localparam logic [1:0] LOWER = 2'b10;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HI    = 2'd2
    } state_t;

endpackage : imm_pkg
`default_nettype wire

// File: rtl/imm_fit_check.sv
`default_nettype none
// ============================================================================
// Module      : imm_fit_check
// Description : Flags 32-bit values that survive a 16->32 sign-extension trip.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_fit_check (
    input  logic [31:0] i_imm,
    output logic        o_fits
);

    // Bits 31..15 must all equal the sign bit of the 16-bit field.
    assign o_fits = (i_imm[31:15] == '0) | (i_imm[31:15] == '1);

endmodule : imm_fit_check
`default_nettype wire

// File: rtl/imm_narrower.sv
`default_nettype none
// ============================================================================
// Module      : imm_narrower
// Description : Narrows 32-bit immediates to a SIMM beat or an UPPER/LOWER pair.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_narrower
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      out_data,
    output logic [1:0]       out_kind,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] split_count
);

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_data;
    logic [1:0]       r_kind;
    logic             r_last;
    logic [15:0]      r_pending;
    logic [CNT_W-1:0] r_cnt;

    logic w_fits;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_new;
    logic w_load_low;

    imm_fit_check u_fit (
        .i_imm  (in_data),
        .o_fits (w_fits)
    );

    assign in_ready   = (r_state == EMPTY) | ((r_state == FULL) & out_ready);
    assign out_valid  = (r_state != EMPTY);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_comb begin
        w_state_next = r_state;
        w_load_new   = 1'b0;
        w_load_low   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_load_new   = 1'b1;
                    w_state_next = w_fits ? FULL : HI;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    if (w_in_xfer) begin
                        w_load_new   = 1'b1;
                        w_state_next = w_fits ? FULL : HI;
                    end else begin
                        w_state_next = EMPTY;
                    end
                end
            end
            HI: begin
                if (w_out_xfer) begin
                    w_load_low   = 1'b1;
                    w_state_next = FULL;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= EMPTY;
            r_data    <= 16'h0000;
            r_kind    <= SIMM;
            r_last    <= 1'b0;
            r_pending <= 16'h0000;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_new) begin
                r_data <= w_fits ? in_data[15:0] : in_data[31:16];
                r_kind <= w_fits ? SIMM : UPPER;
                r_last <= w_fits;
                if (!w_fits) begin
                    r_pending <= in_data[15:0];
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end else if (w_load_low) begin
                // Raw low half; the consumer's ori applies zero-extension.
                r_data <= r_pending;
                r_kind <= LOWER;
                r_last <= 1'b1;
            end
        end
    end

    assign out_data    = r_data;
    assign out_kind    = r_kind;
    assign out_last    = r_last;
    assign split_count = r_cnt;

endmodule : imm_narrower
`default_nettype wire

// File: tb/tb_imm_narrower.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_narrower
// Description : Randomised self-checking bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_narrower;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [1:0]  out_kind;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] split_count;

    logic        s_in_ready;
    logic [15:0] s_out_data;
    logic [1:0]  s_out_kind;
    logic        s_out_last;
    logic        s_out_valid;
    logic [1:0]  s_split_count;

    int n_checks;
    int n_errors;

    // Expected beats as {kind, last, data}
    logic [18:0] q_beats[$];
    int          m_splits;

    imm_narrower #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_kind    (out_kind),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .split_count (split_count)
    );

    imm_narrower #(.CNT_W(2)) dut_small (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .out_data    (s_out_data),
        .out_kind    (s_out_kind),
        .out_last    (s_out_last),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .split_count (s_split_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_fits(input logic [31:0] d);
        int v;
        v = int'($signed(d));
        return (v >= -32768) && (v <= 32767);
    endfunction

    // One clock cycle: drive at negedge, check against the model, update it.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, output bit accepted);
        int  sz;
        bit  exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        sz      = q_beats.size();
        exp_rdy = (sz == 0) || (sz == 1 && r);
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("split_count", 32'(split_count), 32'((m_splits > 65535) ? 65535 : m_splits));
        check("split_count_w2", 32'(s_split_count), 32'((m_splits > 3) ? 3 : m_splits));
        if (sz != 0 && out_valid) begin
            check("beat", 32'({out_kind, out_last, out_data}), 32'(q_beats[0]));
        end
        if (sz != 0 && r) void'(q_beats.pop_front());
        accepted = v && exp_rdy;
        if (accepted) begin
            if (model_fits(d)) begin
                q_beats.push_back({2'b00, 1'b1, d[15:0]});
            end else begin
                q_beats.push_back({2'b01, 1'b0, d[31:16]});
                q_beats.push_back({2'b10, 1'b1, d[15:0]});
                m_splits++;
            end
        end
    endtask

    task automatic send(input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) cycle(1'b1, d, 1'b1, acc);
        if (!acc) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 10 && q_beats.size() != 0; i++) cycle(1'b0, 32'h0, 1'b1, acc);
        check("drain", 32'(q_beats.size()), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        q_beats.delete();
        m_splits = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_kind", 32'(out_kind), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_split_count", 32'(split_count), 32'(0));
        check("rst_split_count_w2", 32'(s_split_count), 32'(0));
    endtask

    initial begin
        bit          acc;
        logic [31:0] bnd[4];
        logic [31:0] r32;
        n_checks  = 0;
        n_errors  = 0;
        m_splits  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Back-to-back fitting words
        cycle(1'b1, 32'hFFFFF000, 1'b1, acc);
        cycle(1'b1, 32'h00000011, 1'b1, acc);
        cycle(1'b1, 32'hFFFF9999, 1'b1, acc);
        drain();

        // Split with consumer always ready
        send(32'h00008310);
        drain();

        // Split held by a stalled consumer
        cycle(1'b1, 32'h12345678, 1'b0, acc);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, acc);
        drain();

        // Boundary values
        bnd[0] = 32'h00007FFF;
        bnd[1] = 32'hFFFF8000;
        bnd[2] = 32'h00008000;
        bnd[3] = 32'hFFFF7FFF;
        for (int i = 0; i < 4; i++) send(bnd[i]);
        drain();

        // Reset while the LOWER half is pending
        cycle(1'b1, 32'hDEADBEEF, 1'b0, acc);
        cycle(1'b0, 32'h0, 1'b0, acc);
        do_reset();
        repeat (3) cycle(1'b0, 32'h0, 1'b1, acc);

        // Counter saturation on the narrow instance
        for (int i = 0; i < 5; i++) begin
            send(32'h00010000 + 32'(i));
        end
        drain();

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            r32 = $urandom;
            case ($urandom_range(0, 3))
                0: r32 = {{16{r32[15]}}, r32[15:0]};
                1: ;
                2: r32 = bnd[$urandom_range(0, 3)];
                default: r32 = 32'($signed(r32[17:0]));
            endcase
            cycle(($urandom_range(0, 3) != 0), r32, ($urandom_range(0, 9) < 7), acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_imm_narrower
`default_nettype wire
